// File: rtl/serde_rtl_pkg.sv
// Shared types and byte constants for the serde JSON5 scanner.
// Comment-stripping states exist only when SERDE_JSON5_COMMENT_EN is defined.
package serde_rtl_pkg;

   typedef enum logic [3:0] {
      EV_OPEN_MAP  = 4'd0,
      EV_CLOSE_MAP = 4'd1,
      EV_OPEN_SEQ  = 4'd2,
      EV_CLOSE_SEQ = 4'd3,
      EV_KEY_SEP   = 4'd4,
      EV_ITEM_SEP  = 4'd5,
      EV_STR_START = 4'd6,
      EV_STR_END   = 4'd7,
      EV_DATA      = 4'd8,
      EV_END       = 4'd9
   } ev_kind_e;

   typedef enum logic [2:0] {
      ERR_NONE         = 3'd0,
      ERR_OVERFLOW     = 3'd1,
      ERR_UNDERFLOW    = 3'd2,
      ERR_MISMATCH     = 3'd3,
      ERR_BAD_COMMENT  = 3'd4,
      ERR_UNTERMINATED = 3'd5
   } err_e;

   typedef enum logic [3:0] {
      ST_NORMAL   = 4'd0,
      ST_STR      = 4'd1,
      ST_STR_ESC  = 4'd2,
      ST_END      = 4'd3,
      ST_ERROR    = 4'd4
`ifdef SERDE_JSON5_COMMENT_EN
      ,
      ST_SLASH    = 4'd5,
      ST_LINE_CMT = 4'd6,
      ST_BLK_CMT  = 4'd7,
      ST_BLK_STAR = 4'd8
`endif
   } scan_state_e;

   localparam logic KIND_MAP = 1'b1;
   localparam logic KIND_SEQ = 1'b0;

   localparam logic [7:0] CH_LBRACE = 8'h7B;
   localparam logic [7:0] CH_RBRACE = 8'h7D;
   localparam logic [7:0] CH_LBRACK = 8'h5B;
   localparam logic [7:0] CH_RBRACK = 8'h5D;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_DQUOTE = 8'h22;
   localparam logic [7:0] CH_SQUOTE = 8'h27;
   localparam logic [7:0] CH_BSLASH = 8'h5C;
   localparam logic [7:0] CH_SLASH  = 8'h2F;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_SP     = 8'h20;
   localparam logic [7:0] CH_TAB    = 8'h09;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

endpackage

// File: rtl/serde_nest_stack.sv
// One-bit-per-level container stack (1=map, 0=seq) with a depth counter.
module serde_nest_stack
   import serde_rtl_pkg::*;
#(
   parameter int MAX_DEPTH = 16,
   localparam int DW = $clog2(MAX_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          kind_in,
   input  logic          clear,
   output logic          top_kind,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);

   logic [MAX_DEPTH-1:0] stack_q, stack_d;
   logic [DW-1:0]        depth_q, depth_d;

   assign depth = depth_q;
   assign full  = (depth_q == DW'(MAX_DEPTH));
   assign empty = (depth_q == '0);

   always_comb begin
      stack_d  = stack_q;
      depth_d  = depth_q;
      top_kind = KIND_SEQ;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (DW'(i + 1) == depth_q) top_kind = stack_q[i];
      end
      if (clear) begin
         stack_d = '0;
         depth_d = '0;
      end else if (push && !full) begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DW'(i) == depth_q) stack_d[i] = kind_in;
         end
         depth_d = depth_q + DW'(1);
      end else if (pop && !empty) begin
         depth_d = depth_q - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stack_q <= '0;
         depth_q <= '0;
      end else begin
         stack_q <= stack_d;
         depth_q <= depth_d;
      end
   end

   a_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule

// File: rtl/serde_json5_scanner.sv
// Streaming JSON5 structural scanner: one byte in, at most one event out per cycle.
// Define SERDE_JSON5_COMMENT_EN to strip // and /* */ comments.
//
// state       | meaning
// ST_NORMAL   | between tokens, structural bytes decoded
// ST_STR      | inside a string opened by quote_q
// ST_STR_ESC  | byte after a backslash inside a string
// ST_SLASH    | saw '/', waiting for '/' or '*'
// ST_LINE_CMT | line comment, runs until LF
// ST_BLK_CMT  | block comment body
// ST_BLK_STAR | block comment, last byte was '*'
// ST_END      | document done, EV_END waiting for the output register
// ST_ERROR    | sticky error, input sunk until rst
module serde_json5_scanner
   import serde_rtl_pkg::*;
#(
   parameter int MAX_DEPTH = 16,
   localparam int DW = $clog2(MAX_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   input  logic          in_last,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic [3:0]    ev_kind,
   output logic [7:0]    ev_data,
   output logic [DW-1:0] ev_depth,
   output logic          err,
   output logic [2:0]    err_code
);

   scan_state_e   state_q, state_d;
   logic [7:0]    quote_q, quote_d;
   logic          ev_valid_q, ev_valid_d;
   ev_kind_e      ev_kind_q, ev_kind_d;
   logic [7:0]    ev_data_q, ev_data_d;
   logic [DW-1:0] ev_depth_q, ev_depth_d;
   logic          err_q, err_d;
   err_e          err_code_q, err_code_d;

   logic          stk_push, stk_pop, stk_kind, stk_clear, stk_top, stk_full, stk_empty;
   logic [DW-1:0] depth, depth_next;

   logic          out_free, xfer, emit, unterm;
   ev_kind_e      ekind;
   logic [DW-1:0] edepth;
   scan_state_e   nstate;
   err_e          berr;

   serde_nest_stack #(.MAX_DEPTH(MAX_DEPTH)) u_stack (
      .clk      (clk),
      .rst      (rst),
      .push     (stk_push),
      .pop      (stk_pop),
      .kind_in  (stk_kind),
      .clear    (stk_clear),
      .top_kind (stk_top),
      .depth    (depth),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   assign out_free = !ev_valid_q || ev_ready;
   assign in_ready = !rst && (state_q == ST_ERROR || (state_q != ST_END && out_free));
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      quote_d    = quote_q;
      ev_valid_d = ev_valid_q && !ev_ready;
      ev_kind_d  = ev_kind_q;
      ev_data_d  = ev_data_q;
      ev_depth_d = ev_depth_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
      stk_kind   = KIND_SEQ;
      stk_clear  = 1'b0;
      emit       = 1'b0;
      ekind      = EV_DATA;
      edepth     = depth;
      nstate     = state_q;
      berr       = ERR_NONE;
      depth_next = depth;
      unterm     = 1'b0;

      if (state_q == ST_END) begin
         if (out_free) begin
            ev_valid_d = 1'b1;
            ev_kind_d  = EV_END;
            ev_data_d  = 8'h00;
            ev_depth_d = '0;
            stk_clear  = 1'b1;
            state_d    = ST_NORMAL;
         end
      end else if (state_q != ST_ERROR && xfer) begin
         case (state_q)
            ST_NORMAL: begin
               case (in_data)
                  CH_LBRACE, CH_LBRACK: begin
                     if (stk_full) begin
                        berr = ERR_OVERFLOW;
                     end else begin
                        stk_push = 1'b1;
                        stk_kind = (in_data == CH_LBRACE) ? KIND_MAP : KIND_SEQ;
                        emit     = 1'b1;
                        ekind    = (in_data == CH_LBRACE) ? EV_OPEN_MAP : EV_OPEN_SEQ;
                        edepth   = depth + DW'(1);
                     end
                  end
                  CH_RBRACE, CH_RBRACK: begin
                     if (stk_empty) begin
                        berr = ERR_UNDERFLOW;
                     end else if (stk_top != ((in_data == CH_RBRACE) ? KIND_MAP : KIND_SEQ)) begin
                        berr = ERR_MISMATCH;
                     end else begin
                        stk_pop = 1'b1;
                        emit    = 1'b1;
                        ekind   = (in_data == CH_RBRACE) ? EV_CLOSE_MAP : EV_CLOSE_SEQ;
                     end
                  end
                  CH_COLON: begin
                     emit  = 1'b1;
                     ekind = EV_KEY_SEP;
                  end
                  CH_COMMA: begin
                     emit  = 1'b1;
                     ekind = EV_ITEM_SEP;
                  end
                  CH_DQUOTE, CH_SQUOTE: begin
                     quote_d = in_data;
                     emit    = 1'b1;
                     ekind   = EV_STR_START;
                     nstate  = ST_STR;
                  end
                  CH_SP, CH_TAB, CH_CR, CH_LF: ;
`ifdef SERDE_JSON5_COMMENT_EN
                  CH_SLASH: nstate = ST_SLASH;
`endif
                  default: emit = 1'b1;
               endcase
            end
            ST_STR: begin
               emit = 1'b1;
               if (in_data == quote_q) begin
                  ekind  = EV_STR_END;
                  nstate = ST_NORMAL;
               end else if (in_data == CH_BSLASH) begin
                  nstate = ST_STR_ESC;
               end
            end
            ST_STR_ESC: begin
               emit   = 1'b1;
               nstate = ST_STR;
            end
`ifdef SERDE_JSON5_COMMENT_EN
            ST_SLASH: begin
               if (in_data == CH_SLASH)     nstate = ST_LINE_CMT;
               else if (in_data == CH_STAR) nstate = ST_BLK_CMT;
               else                         berr   = ERR_BAD_COMMENT;
            end
            ST_LINE_CMT: if (in_data == CH_LF) nstate = ST_NORMAL;
            ST_BLK_CMT:  if (in_data == CH_STAR) nstate = ST_BLK_STAR;
            ST_BLK_STAR: begin
               if (in_data == CH_SLASH)      nstate = ST_NORMAL;
               else if (in_data != CH_STAR)  nstate = ST_BLK_CMT;
            end
`endif
            default: ;
         endcase

         if (stk_push)     depth_next = depth + DW'(1);
         else if (stk_pop) depth_next = depth - DW'(1);
         unterm = (depth_next != '0) || nstate == ST_STR || nstate == ST_STR_ESC;
`ifdef SERDE_JSON5_COMMENT_EN
         unterm = unterm || nstate == ST_SLASH || nstate == ST_BLK_CMT || nstate == ST_BLK_STAR;
`endif

         if (berr != ERR_NONE) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = berr;
         end else begin
            if (emit) begin
               ev_valid_d = 1'b1;
               ev_kind_d  = ekind;
               ev_data_d  = in_data;
               ev_depth_d = edepth;
            end
            state_d = nstate;
            // The last byte's own event still goes out before the document verdict.
            if (in_last) begin
               if (unterm) begin
                  state_d    = ST_ERROR;
                  err_d      = 1'b1;
                  err_code_d = ERR_UNTERMINATED;
               end else begin
                  state_d = ST_END;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_NORMAL;
         quote_q    <= 8'h00;
         ev_valid_q <= 1'b0;
         ev_kind_q  <= EV_OPEN_MAP;
         ev_data_q  <= 8'h00;
         ev_depth_q <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         quote_q    <= quote_d;
         ev_valid_q <= ev_valid_d;
         ev_kind_q  <= ev_kind_d;
         ev_data_q  <= ev_data_d;
         ev_depth_q <= ev_depth_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_kind  = ev_kind_q;
   assign ev_data  = ev_data_q;
   assign ev_depth = ev_depth_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_serde_json5_scanner.sv
// Directed bench for serde_json5_scanner with an event scoreboard and stall-hold checking.
module tb_serde_json5_scanner;
   import serde_rtl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_last;
   logic [7:0] in_data;
   logic       ev_valid, ev_ready;
   logic [3:0] ev_kind;
   logic [7:0] ev_data;
   logic [4:0] ev_depth;
   logic       err;
   logic [2:0] err_code;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic rand_rdy = 1'b0;

   logic [19:0] got_q[$];
   logic [19:0] exp_q[$];
   logic        stall_p = 1'b0;
   logic [19:0] stall_v;

   serde_json5_scanner #(.MAX_DEPTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_kind  (ev_kind),
      .ev_data  (ev_data),
      .ev_depth (ev_depth),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      ev_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ev_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // END carries no meaningful byte, so only its kind and depth are scored.
   always @(negedge clk) begin
      if (rst) begin
         stall_p = 1'b0;
      end else begin
         if (stall_p)
            chk("stall_hold", {11'd0, ev_valid, ev_kind, ev_data, 8'(ev_depth)}, {11'd0, 1'b1, stall_v});
         if (ev_valid && ev_ready)
            got_q.push_back({ev_kind, (ev_kind == 4'(EV_END)) ? 8'h00 : ev_data, 8'(ev_depth)});
         stall_p = ev_valid && !ev_ready;
         stall_v = {ev_kind, ev_data, 8'(ev_depth)};
      end
   end

   task automatic add(input ev_kind_e k, input logic [7:0] d, input int dep);
      exp_q.push_back({4'(k), (k == EV_END) ? 8'h00 : d, 8'(dep)});
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      in_last  = last;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_str(input string s, input logic last);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
   endtask

   task automatic wait_events(input int n);
      int t = 0;
      while (got_q.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string tag);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_ev%0d", tag, i), {12'd0, got_q[i]}, {12'd0, exp_q[i]});
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_idle(input string tag);
      @(negedge clk);
      chk({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
      chk({tag, "_ev_kind"},  32'(ev_kind),  32'd0);
      chk({tag, "_ev_data"},  32'(ev_data),  32'd0);
      chk({tag, "_ev_depth"}, 32'(ev_depth), 32'd0);
      chk({tag, "_err"},      32'(err),      32'd0);
      chk({tag, "_err_code"}, 32'(err_code), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_idle("reset");

      // Basic document at full rate
      t0 = cyc;
      send_str("{\"a\":[1,2]}", 1'b1);
      chk("doc_cycles", 32'(cyc - t0), 32'd11);
      add(EV_OPEN_MAP, "{", 1);  add(EV_STR_START, "\"", 1); add(EV_DATA, "a", 1);
      add(EV_STR_END, "\"", 1);  add(EV_KEY_SEP, ":", 1);    add(EV_OPEN_SEQ, "[", 2);
      add(EV_DATA, "1", 2);      add(EV_ITEM_SEP, ",", 2);   add(EV_DATA, "2", 2);
      add(EV_CLOSE_SEQ, "]", 2); add(EV_CLOSE_MAP, "}", 1);  add(EV_END, 8'h00, 0);
      wait_events(12);
      compare("doc");
      chk("doc_err", 32'(err), 32'd0);
      chk("doc_ready_after_end", 32'(in_ready), 32'd1);

      // Overflow at MAX_DEPTH
      do_reset();
      for (int i = 0; i < 17; i++) send_byte("[", 1'b0);
      for (int i = 1; i <= 16; i++) add(EV_OPEN_SEQ, "[", i);
      wait_events(16);
      compare("ovf");
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_code", 32'(err_code), 32'd1);
      send_str("]]a", 1'b1);
      wait_events(0);
      compare("ovf_quiet");
      chk("ovf_code_sticky", 32'(err_code), 32'd1);

      // Mismatch and underflow
      do_reset();
      send_str("[}", 1'b0);
      add(EV_OPEN_SEQ, "[", 1);
      wait_events(1);
      compare("mis");
      chk("mis_code", 32'(err_code), 32'd3);
      do_reset();
      send_str("]", 1'b0);
      wait_events(0);
      compare("unf");
      chk("unf_err", 32'(err), 32'd1);
      chk("unf_code", 32'(err_code), 32'd2);

      // Single-quoted string with escape and foreign quote
      do_reset();
      send_str("['x\\'\"',1]", 1'b1);
      add(EV_OPEN_SEQ, "[", 1);  add(EV_STR_START, "'", 1); add(EV_DATA, "x", 1);
      add(EV_DATA, "\\", 1);     add(EV_DATA, "'", 1);      add(EV_DATA, "\"", 1);
      add(EV_STR_END, "'", 1);   add(EV_ITEM_SEP, ",", 1);  add(EV_DATA, "1", 1);
      add(EV_CLOSE_SEQ, "]", 1); add(EV_END, 8'h00, 0);
      wait_events(11);
      compare("str");
      chk("str_err", 32'(err), 32'd0);

      do_reset();
`ifdef SERDE_JSON5_COMMENT_EN
      send_str("[1/*a*b*/,//c\n2]", 1'b1);
      add(EV_OPEN_SEQ, "[", 1); add(EV_DATA, "1", 1);    add(EV_ITEM_SEP, ",", 1);
      add(EV_DATA, "2", 1);     add(EV_CLOSE_SEQ, "]", 1); add(EV_END, 8'h00, 0);
      wait_events(6);
      compare("cmt");
      chk("cmt_err", 32'(err), 32'd0);
      do_reset();
      send_str("[1/2]", 1'b0);
      add(EV_OPEN_SEQ, "[", 1); add(EV_DATA, "1", 1);
      wait_events(2);
      compare("badcmt");
      chk("badcmt_code", 32'(err_code), 32'd4);
`else
      send_str("[1/2]", 1'b1);
      add(EV_OPEN_SEQ, "[", 1); add(EV_DATA, "1", 1); add(EV_DATA, "/", 1);
      add(EV_DATA, "2", 1);     add(EV_CLOSE_SEQ, "]", 1); add(EV_END, 8'h00, 0);
      wait_events(6);
      compare("slash");
      chk("slash_err", 32'(err), 32'd0);
`endif

      // Random backpressure
      do_reset();
      rand_rdy = 1'b1;
      send_str("{\"k\":[1,'v',2]}", 1'b1);
      add(EV_OPEN_MAP, "{", 1);  add(EV_STR_START, "\"", 1); add(EV_DATA, "k", 1);
      add(EV_STR_END, "\"", 1);  add(EV_KEY_SEP, ":", 1);    add(EV_OPEN_SEQ, "[", 2);
      add(EV_DATA, "1", 2);      add(EV_ITEM_SEP, ",", 2);   add(EV_STR_START, "'", 2);
      add(EV_DATA, "v", 2);      add(EV_STR_END, "'", 2);    add(EV_ITEM_SEP, ",", 2);
      add(EV_DATA, "2", 2);      add(EV_CLOSE_SEQ, "]", 2);  add(EV_CLOSE_MAP, "}", 1);
      add(EV_END, 8'h00, 0);
      wait_events(16);
      compare("bp");
      chk("bp_err", 32'(err), 32'd0);

      // Reset mid-string
      send_str("[\"ab", 1'b0);
      do_reset();
      rand_rdy = 1'b0;
      chk_idle("midrst");
      send_str("{}", 1'b1);
      add(EV_OPEN_MAP, "{", 1); add(EV_CLOSE_MAP, "}", 1); add(EV_END, 8'h00, 0);
      wait_events(3);
      compare("post_rst");
      chk("post_rst_err", 32'(err), 32'd0);

      // Unterminated string at in_last
      send_str("\"ab", 1'b1);
      add(EV_STR_START, "\"", 0); add(EV_DATA, "a", 0); add(EV_DATA, "b", 0);
      wait_events(3);
      compare("unterm");
      chk("unterm_err", 32'(err), 32'd1);
      chk("unterm_code", 32'(err_code), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired after %0d cycles", cyc);
      $fatal(1, "watchdog");
   end

endmodule
